adder_result_display: RTL



---
 rtl/adder_result_display.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/adder_result_display.sv
// Captures an add/sub stage result on a strobe and shows it on a 4-digit muxed seven-segment display.
// Latency: out_valid one edge after capture; digits refresh at the next slot start. No backpressure.
// Optional overflow blink: `define ADDER_DISP_BLINK_OVF_EN.
module adder_result_display #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_ROUNDS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_result,
  input  logic       in_carry,
  input  logic       in_zero,
  input  logic       in_overflow,
  input  logic       hold,
  input  logic       clr,
  output logic       out_valid,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_O     = 8'hA3;

  typedef enum logic {EMPTY = 1'b0, SHOW = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [3:0]         res_q, res_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [1:0]         idx_q, idx_d;
  logic [3:0]         an_q, an_d;
  logic [7:0]         seg_q, seg_d;

  logic capture;
  logic div_wrap;
  logic slot_start;

  assign capture    = in_valid & ~hold & ~clr;
  assign div_wrap   = (div_q == DIV_W'(SCAN_DIV - 1));
  assign slot_start = (div_q == '0);

  function automatic logic [7:0] hex_glyph(input logic [2:0] m);
    case (m)
      3'd0:    hex_glyph = 8'hC0;
      3'd1:    hex_glyph = 8'hF9;
      3'd2:    hex_glyph = 8'hA4;
      3'd3:    hex_glyph = 8'hB0;
      3'd4:    hex_glyph = 8'h99;
      3'd5:    hex_glyph = 8'h92;
      3'd6:    hex_glyph = 8'h82;
      default: hex_glyph = 8'hF8;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = EMPTY;
    end else if (capture) begin
      state_d = SHOW;
    end
  end

  // Output decode
  always_comb begin
    out_valid = (state_q == SHOW);
  end

  always_comb begin
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    if (capture) begin
      res_d   = in_result;
      carry_d = in_carry;
      zero_d  = in_zero;
      ovf_d   = in_overflow;
    end
  end

  always_comb begin
    div_d = div_wrap ? '0 : div_q + 1'b1;
    idx_d = div_wrap ? idx_q + 2'd1 : idx_q;
  end

`ifdef ADDER_DISP_BLINK_OVF_EN
  localparam int BLINK_W = (BLINK_ROUNDS > 1) ? $clog2(BLINK_ROUNDS) : 1;

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;
  logic               round_done;

  assign round_done = div_wrap & (idx_q == 2'd3);

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (capture || clr) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (round_done) begin
      if (blink_cnt_q == BLINK_W'(BLINK_ROUNDS - 1)) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end
`endif

  // an and seg load together at each slot start so they always describe the same digit
  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    if (slot_start) begin
      an_d = ~(4'b0001 << idx_q);
      if (state_q == EMPTY) begin
        seg_d = SEG_DASH;
      end else begin
        case (idx_q)
          2'd3:    seg_d = (res_q[3] && !zero_q) ? SEG_DASH : SEG_BLANK;
          2'd2:    seg_d = ovf_q ? SEG_E : hex_glyph(res_q[2:0]);
          2'd1:    seg_d = carry_q ? SEG_C : SEG_BLANK;
          default: begin
            seg_d    = ovf_q ? SEG_O : SEG_BLANK;
            seg_d[7] = ~zero_q;
          end
        endcase
      end
`ifdef ADDER_DISP_BLINK_OVF_EN
      if ((state_q == SHOW) && ovf_q && phase_q) begin
        an_d = 4'b1111;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      div_q   <= '0;
      idx_q   <= '0;
      an_q    <= 4'b1111;
      seg_q   <= 8'hFF;
    end else begin
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule
